// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: state
// encoding, parity-type codes, default bit period and the parity helper.
package uart_pkg;

    localparam int CyclesPerBitDefault = 16;

    typedef enum logic [2:0] {
        Idle   = 3'd0,
        Start  = 3'd1,
        Data   = 3'd2,
        Parity = 3'd3,
        Stop1  = 3'd4,
        Stop2  = 3'd5
    } state_e;

    localparam logic [1:0] ParityNone = 2'd0;
    localparam logic [1:0] ParityEven = 2'd2;
    localparam logic [1:0] ParityOdd  = 2'd3;

    // Parity bit that makes the total count of ones even (odd = 0) or odd (odd = 1).
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/register_d.sv
// Generic enabled D register with asynchronous active-high reset.
module register_d #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled; reset forces the configured reset value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sync_parallel_counter.sv
// Up-counter with synchronous clear (priority over enable) and
// asynchronous active-high reset.
module sync_parallel_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Clear wins over increment; the counter wraps naturally at its width.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte over valid/ready and sends
// start, 8 data bits LSB first, optional parity, and 1 or 2 stop bits.
// txd and tx_done come straight from flops so the line never glitches.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = CyclesPerBitDefault
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_en,
    input  logic [1:0] parity_type,
    input  logic       nstop,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       ready,
    output logic       txd,
    output logic       tx_done
);

    localparam int              CntW    = $clog2(CYCLES_PER_BIT);
    localparam logic [CntW-1:0] BitLast = CntW'(CYCLES_PER_BIT - 1);

    state_e state_q;
    state_e state_d;

    logic [CntW-1:0] bit_cnt_q;
    logic            bit_cnt_clear;
    logic            bit_end;

    logic [2:0]      data_cnt_q;
    logic            data_cnt_clear;
    logic            data_cnt_en;

    logic [7:0]      shift_q;
    logic [7:0]      shift_d;

    // Frame configuration captured at accept: {nstop, parity_type, data}.
    logic [10:0]     cfg_q;
    logic [7:0]      data_lat_q;
    logic [1:0]      ptype_q;
    logic            nstop_q;

    logic            txd_q;
    logic            txd_d;
    logic            tx_done_q;
    logic            tx_done_d;

    logic            accept;

    assign data_lat_q = cfg_q[7:0];
    assign ptype_q    = cfg_q[9:8];
    assign nstop_q    = cfg_q[10];

    // Reset is folded into ready so the handshake is closed while reset is held.
    assign ready   = (state_q == Idle) && tx_en && !reset;
    assign accept  = data_valid && ready;
    assign bit_end = (bit_cnt_q == BitLast);

    // The bit timer idles at zero and restarts at every bit boundary.
    assign bit_cnt_clear = (state_q == Idle) || bit_end;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, shift-register and counter control.
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        data_cnt_clear = 1'b0;
        data_cnt_en    = 1'b0;
        tx_done_d      = 1'b0;
        case (state_q)
            Idle: begin
                if (accept) begin
                    state_d = Start;
                    shift_d = data_in;
                end
            end
            Start: begin
                if (bit_end) begin
                    state_d        = Data;
                    data_cnt_clear = 1'b1;
                end
            end
            Data: begin
                if (bit_end) begin
                    shift_d     = {1'b0, shift_q[7:1]};
                    data_cnt_en = 1'b1;
                    if (data_cnt_q == 3'd7) begin
                        state_d = ptype_q[1] ? Parity : Stop1;
                    end
                end
            end
            Parity: begin
                if (bit_end) begin
                    state_d = Stop1;
                end
            end
            Stop1: begin
                if (bit_end) begin
                    if (nstop_q) begin
                        state_d = Stop2;
                    end else begin
                        state_d   = Idle;
                        tx_done_d = 1'b1;
                    end
                end
            end
            Stop2: begin
                if (bit_end) begin
                    state_d   = Idle;
                    tx_done_d = 1'b1;
                end
            end
            default: begin
                state_d = Idle;
            end
        endcase
    end

    // Line level for the upcoming state, so the txd flop lines up with it.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            Idle:    txd_d = 1'b1;
            Start:   txd_d = 1'b0;
            Data:    txd_d = shift_d[0];
            Parity:  txd_d = parity_bit(data_lat_q, ptype_q[0]);
            Stop1:   txd_d = 1'b1;
            Stop2:   txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
    end

    sync_parallel_counter #(.WIDTH(CntW)) u_bit_cnt (
        .clock (clock),
        .reset (reset),
        .clear (bit_cnt_clear),
        .en    (1'b1),
        .count (bit_cnt_q)
    );

    sync_parallel_counter #(.WIDTH(3)) u_data_cnt (
        .clock (clock),
        .reset (reset),
        .clear (data_cnt_clear),
        .en    (data_cnt_en),
        .count (data_cnt_q)
    );

    register_d #(.WIDTH(8)) u_shift (
        .clock (clock),
        .reset (reset),
        .en    (1'b1),
        .d     (shift_d),
        .q     (shift_q)
    );

    register_d #(.WIDTH(11)) u_cfg (
        .clock (clock),
        .reset (reset),
        .en    (accept),
        .d     ({nstop, parity_type, data_in}),
        .q     (cfg_q)
    );

    register_d #(.WIDTH(1), .RESET_VALUE(1'b1)) u_txd (
        .clock (clock),
        .reset (reset),
        .en    (1'b1),
        .d     (txd_d),
        .q     (txd_q)
    );

    register_d #(.WIDTH(1)) u_tx_done (
        .clock (clock),
        .reset (reset),
        .en    (1'b1),
        .d     (tx_done_d),
        .q     (tx_done_q)
    );

    assign txd     = txd_q;
    assign tx_done = tx_done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; pairs with the team's majority-voting UART receiver, and the frame format is identical.
- Takes a byte over a valid/ready handshake and serializes it on txd: start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Each bit lasts CYCLES_PER_BIT clocks; the clock is the same 16x baud clock that feeds the receiver.
- Sits in the UART peripheral next to the receiver, driven by the peripheral's register/FIFO interface.

Parameters:
- CYCLES_PER_BIT, 16, clock cycles per serial bit. Must be 16 for compatibility with the receiver; the counter width is $clog2(CYCLES_PER_BIT).

Ports:
- clock  input  1  system clock (16x baud)
- reset  input  1  asynchronous, active-high reset
- tx_en  input  1  enables the transmitter; sampled only in Idle
- parity_type  input  2  0/1: no parity, 2: even, 3: odd
- nstop  input  1  0: one stop bit, 1: two stop bits
- data_in  input  8  byte to transmit
- data_valid  input  1  data_in is valid (handshake request)
- ready  output  1  transmitter can accept a byte
- txd  output  1  serial output line; idle high
- tx_done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (asynchronous, active-high):
  - State is Idle; txd=1, ready=0 until tx_en is high, tx_done=0.
  - Shift register and counters clear.
  - Reset mid-frame aborts immediately: txd returns high in the same cycle, with no glitch to 0.
- Registered outputs: txd is driven from a flop, never decoded combinationally.
- Handshake:
  - ready = (state==Idle) & tx_en.
  - A byte is accepted when data_valid & ready on a rising clock edge.
  - On accept, data_in, parity_type and nstop are latched. Changes to these inputs mid-frame have no effect.
- Start timing: the cycle after accept, txd=0 (start bit) and the bit counter starts at 0. Each bit holds for exactly CYCLES_PER_BIT cycles. bit_end = (bit counter == CYCLES_PER_BIT-1).
- State machine:
  - Idle: txd=1, bit counter held at 0. Go to Start on accept.
  - Start: txd=0. On bit_end go to Data; the data counter clears.
  - Data: txd = shift_reg[0]. On bit_end, shift right and increment the data counter. After 8 bits: go to Parity if parity_type[1], else Stop1.
  - Parity: txd = (^latched_data) ^ parity_type[0]. Even parity gives an even total number of 1s; odd parity gives an odd total. On bit_end go to Stop1.
  - Stop1: txd=1. On bit_end: go to Stop2 if the latched nstop=1; otherwise raise tx_done and go to Idle.
  - Stop2: txd=1. On bit_end raise tx_done and go to Idle.
  - Illegal state encoding: go to Idle.
- tx_done is a registered pulse, high for exactly one cycle, coinciding with the first Idle cycle. ready may be high in that same cycle.
- Back-to-back frames: if data_valid is held high, the next accept occurs in the first Idle cycle. The inter-frame gap is therefore exactly 1 extra idle-high cycle after the stop bit(s).
- Frame length, counted from the first start-bit cycle to the end of the last stop bit: (10 + P + S) * CYCLES_PER_BIT cycles, where P = parity_type[1] and S = nstop.
- tx_en: deasserting it mid-frame does not abort the frame; it only blocks the next accept. With tx_en=0, ready=0 and txd stays 1.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams: Idle=0, Start=1, Data=2, Parity=3, Stop1=4, Stop2=5;
  - parity type constants: ParityNone=0, ParityEven=2, ParityOdd=3;
  - default CYCLES_PER_BIT=16.
- Use the receiver's register and counter blocks in the same way: register_d for the shift register and the txd/tx_done flops, sync_parallel_counter for the bit and data counters.
- No new sub-module is needed.

Test Plan:
- Reset then idle: tx_en=1, no data_valid -> txd=1 and ready=1 for 100 cycles; tx_done never asserted.
- 0x55, parity_type=0, nstop=0 -> txd bit sequence 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles; 160 cycles total; tx_done pulses once at cycle 161 after accept.
- 0xA5 with parity_type=2, then 0xA5 with parity_type=3, nstop=1 -> parity bit 0 for even, 1 for odd; 2 stop bits; frame lengths 176 and 192 cycles.
- Back-to-back 0x00 then 0xFF with data_valid held high -> second start bit begins exactly one cycle after the first frame's tx_done; ready is low throughout each frame.
- Mid-frame disturbances:
  - toggling tx_en and changing data_in/parity_type during Data -> frame unchanged;
  - asserting reset during Data -> txd=1 and ready low within the same cycle; ready returns high after reset deasserts.
- Loopback into the UART receiver (same config) with 256 random bytes under every parity/nstop combination -> every data_out matches, data_valid=1, frame_error=0, parity_error=0.
